// File: rtl/video_pkg.sv
// Shared video subsystem definitions: VRAM geometry, scanline size,
// fetch FSM state encoding and VRAM bank base addresses.
package video_pkg;

   localparam int VRAM_ADDR_WIDTH = 20;
   localparam int VRAM_DATA_WIDTH = 24;
   localparam int LINE_WORDS      = 512;

   // Line fetch engine states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      ISSUE   = 2'd2,
      DRAIN   = 2'd3
   } fetch_state_e;

   // Frame buffer banks
   localparam logic [VRAM_ADDR_WIDTH-1:0] BANK0_BASE = 20'h00000;
   localparam logic [VRAM_ADDR_WIDTH-1:0] BANK1_BASE = 20'h80000;

endpackage

// File: rtl/display_line_fetcher_if.sv
// VRAM arbiter read port. The fetcher is the master (request, read command,
// address); the arbiter is the slave (grant, ready, in-order read data).
interface display_line_fetcher_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 24
);
   logic                  mem_request;
   logic                  mem_grant;
   logic                  mem_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;

   modport master (
      output mem_request, mem_read, mem_address,
      input  mem_grant, mem_ready, mem_rdata, mem_rvalid
   );

   modport slave (
      input  mem_request, mem_read, mem_address,
      output mem_grant, mem_ready, mem_rdata, mem_rvalid
   );
endinterface

// File: rtl/display_line_fetcher_return.sv
// Return path of the line fetcher: registers each returned VRAM word into a
// line buffer write (column/data/valid) one cycle after rvalid, counts the
// words received and flags when the whole line has arrived.
module display_line_fetcher_return #(
   parameter int LINE_WORDS = video_pkg::LINE_WORDS,
   parameter int DATA_WIDTH = video_pkg::VRAM_DATA_WIDTH
) (
   input  logic                          i_master_clk,
   input  logic                          i_reset_n,
   input  logic                          clear,
   input  logic                          enable,
   input  logic                          rvalid,
   input  logic [DATA_WIDTH-1:0]         rdata,
   output logic [$clog2(LINE_WORDS)-1:0] column,
   output logic [DATA_WIDTH-1:0]         data,
   output logic                          data_valid,
   output logic                          done
);
   import video_pkg::*;

   localparam int COL_W = $clog2(LINE_WORDS);
   localparam int CNT_W = COL_W + 1;

   logic [CNT_W-1:0] rx_cnt;
   logic             take;

   // Words outside an active fetch (spurious, or stale after reset) and any
   // beyond a full line are dropped so a line is written exactly once.
   assign done = (rx_cnt == CNT_W'(LINE_WORDS));
   assign take = enable && rvalid && !done;

   // Line buffer write register and receive counter
   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_cnt     <= '0;
         column     <= '0;
         data       <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (clear) begin
            rx_cnt <= '0;
         end else if (take) begin
            column     <= rx_cnt[COL_W-1:0];
            data       <= rdata;
            data_valid <= 1'b1;
            rx_cnt     <= rx_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/display_line_fetcher.sv
// Scanline prefetch engine. On a start pulse, reads LINE_WORDS consecutive
// VRAM words (two 12-bit pixels each) through the arbiter in bursts of at
// most BURST_LEN reads per grant, and streams returned words to the video
// controller's line buffer.
// Optional: DISPLAY_LINE_FETCHER_OVERRUN_EN adds a sticky o_overrun flag
// (start received while busy) with i_overrun_clear.
module display_line_fetcher #(
   parameter int LINE_WORDS = video_pkg::LINE_WORDS,
   parameter int BURST_LEN  = 16,
   parameter int ADDR_WIDTH = video_pkg::VRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = video_pkg::VRAM_DATA_WIDTH
) (
   input  logic                          i_master_clk,
   input  logic                          i_reset_n,
   input  logic [ADDR_WIDTH-1:0]         i_display_address,
   input  logic                          i_display_start,
   output logic [$clog2(LINE_WORDS)-1:0] o_display_column,
   output logic [DATA_WIDTH-1:0]         o_display_data,
   output logic                          o_display_data_valid,
   output logic                          o_busy,
`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
   input  logic                          i_overrun_clear,
   output logic                          o_overrun,
`endif
   display_line_fetcher_if.master        mem
);
   import video_pkg::*;

   localparam int COL_W = $clog2(LINE_WORDS);
   localparam int CNT_W = COL_W + 1;
   localparam int BST_W = $clog2(BURST_LEN) + 1;

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_REQUEST = REQUEST;
   localparam logic [1:0] ST_ISSUE   = ISSUE;
   localparam logic [1:0] ST_DRAIN   = DRAIN;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [CNT_W-1:0]      issue_cnt;
   logic [BST_W-1:0]      burst_cnt;
   logic                  start_ok;
   logic                  accept;
   logic                  burst_last;
   logic                  line_last;
   logic                  rx_done;

   assign start_ok   = (state == ST_IDLE) && i_display_start;
   assign accept     = (state == ST_ISSUE) && mem.mem_ready;
   assign burst_last = (burst_cnt == BST_W'(BURST_LEN - 1));
   assign line_last  = (issue_cnt == CNT_W'(LINE_WORDS - 1));

   // All bus outputs decode from registered state, so a state change is the
   // single registered update that drops request and read together.
   assign o_busy          = (state != ST_IDLE);
   assign mem.mem_request = (state == ST_REQUEST) || (state == ST_ISSUE);
   assign mem.mem_read    = (state == ST_ISSUE);
   // Address wraps modulo 2^ADDR_WIDTH by truncation.
   assign mem.mem_address = mem.mem_read ? base_addr + ADDR_WIDTH'(issue_cnt) : '0;

   // Fetch FSM: request a grant, issue up to BURST_LEN reads per grant,
   // then wait for the last word to come back.
   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         base_addr <= '0;
         issue_cnt <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_display_start) begin
                  base_addr <= i_display_address;
                  issue_cnt <= '0;
                  burst_cnt <= '0;
                  state     <= ST_REQUEST;
               end
            end
            ST_REQUEST: begin
               if (mem.mem_grant) begin
                  burst_cnt <= '0;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (accept) begin
                  issue_cnt <= issue_cnt + CNT_W'(1);
                  burst_cnt <= burst_cnt + BST_W'(1);
               end
               // A lost grant re-requests; issue_cnt keeps the position so
               // the next grant resumes where this one stopped.
               if (accept && line_last)
                  state <= ST_DRAIN;
               else if (accept && burst_last)
                  state <= ST_REQUEST;
               else if (!mem.mem_grant)
                  state <= ST_REQUEST;
            end
            ST_DRAIN: begin
               if (rx_done)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   display_line_fetcher_return #(
      .LINE_WORDS (LINE_WORDS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_return (
      .i_master_clk (i_master_clk),
      .i_reset_n    (i_reset_n),
      .clear        (start_ok),
      .enable       (o_busy),
      .rvalid       (mem.mem_rvalid),
      .rdata        (mem.mem_rdata),
      .column       (o_display_column),
      .data         (o_display_data),
      .data_valid   (o_display_data_valid),
      .done         (rx_done)
   );

`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
   // Sticky overrun: a start while busy sets it; set beats clear.
   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         o_overrun <= 1'b0;
      else if (i_display_start && o_busy)
         o_overrun <= 1'b1;
      else if (i_overrun_clear)
         o_overrun <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_display_line_fetcher.sv
// Directed bench for display_line_fetcher with a behavioural VRAM arbiter.
module tb_display_line_fetcher;
   import video_pkg::*;

   localparam int LW = 512;
   localparam int AW = 20;
   localparam int DW = 24;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] disp_addr  = '0;
   logic          disp_start = 1'b0;
   logic [8:0]    col;
   logic [DW-1:0] ddata;
   logic          dvalid;
   logic          busy;
`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
   logic          ovr_clr = 1'b0;
   logic          overrun;
`endif

   display_line_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

   display_line_fetcher #(
      .LINE_WORDS (LW), .BURST_LEN (16), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
   ) dut (
      .i_master_clk         (clk),
      .i_reset_n            (rst_n),
      .i_display_address    (disp_addr),
      .i_display_start      (disp_start),
      .o_display_column     (col),
      .o_display_data       (ddata),
      .o_display_data_valid (dvalid),
      .o_busy               (busy),
`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
      .i_overrun_clear      (ovr_clr),
      .o_overrun            (overrun),
`endif
      .mem                  (mem_if)
   );

   int tests = 0;
   int fails = 0;

   // arbiter model controls and observations
   int  cyc = 0, lat = 3, revoke_at = -1, revoke_hold = 0, revoke_cyc = -10;
   bit  rnd_ready = 1'b0;
   int  issued, seq_err, episodes, writes, wr_err, first_bad, last_wr_cyc, busy_fall_cyc;
   logic          read_after_revoke;
   logic [AW-1:0] resume_addr;
   logic [DW-1:0] col256_data;
   logic [AW-1:0] base = '0;
   logic          prev_busy = 1'b0;

   typedef struct { logic [DW-1:0] d; int due; } rsp_t;
   rsp_t rsp_q[$];

   // VRAM contents: a distinct word per address
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[11:0] ^ 12'h5A3, a[19:8] + 12'h1C7};
   endfunction

   // Arbiter + line buffer observer, acting between clock edges
   always @(negedge clk) begin
      cyc++;
      if (cyc == revoke_cyc + 1) read_after_revoke = mem_if.mem_read;
      if (dvalid) begin
         if (col !== 9'(writes % LW) || ddata !== mem_word(base + AW'(col))) begin
            if (wr_err == 0) first_bad = writes;
            wr_err++;
         end
         if (col == 9'd256) col256_data = ddata;
         if (col == 9'd511) last_wr_cyc = cyc;
         writes++;
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if (revoke_hold > 0) begin
         mem_if.mem_grant = 1'b0;
         revoke_hold--;
      end else if (revoke_at >= 0 && issued == revoke_at && mem_if.mem_read) begin
         mem_if.mem_grant = 1'b0;
         revoke_hold = 2;
         revoke_at = -1;
         revoke_cyc = cyc;
      end else begin
         mem_if.mem_grant = mem_if.mem_request;
      end
      mem_if.mem_ready = mem_if.mem_grant && mem_if.mem_read &&
                         (!rnd_ready || $urandom_range(0, 1) == 1);
      if (mem_if.mem_ready) begin
         if (mem_if.mem_address !== base + AW'(issued)) seq_err++;
         if (issued == 5) resume_addr = mem_if.mem_address;
         rsp_q.push_back('{mem_word(mem_if.mem_address), cyc + lat});
         issued++;
      end
      if (mem_if.mem_grant && mem_if.mem_request && !mem_if.mem_read) episodes++;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         mem_if.mem_rvalid = 1'b1;
         mem_if.mem_rdata  = rsp_q[0].d;
         void'(rsp_q.pop_front());
      end else begin
         mem_if.mem_rvalid = 1'b0;
         mem_if.mem_rdata  = '0;
      end
   end

   task automatic clear_stats();
      issued = 0; seq_err = 0; episodes = 0; writes = 0; wr_err = 0; first_bad = -1;
      last_wr_cyc = -100; busy_fall_cyc = -200; col256_data = '0; resume_addr = '0;
      read_after_revoke = 1'bx;
   endtask

   task automatic pulse_start(input logic [AW-1:0] a, input bit new_line);
      @(posedge clk); #1;
      if (new_line) begin
         clear_stats();
         base = a;
      end
      disp_addr  = a;
      disp_start = 1'b1;
      @(posedge clk); #1;
      disp_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", name, busy, n);
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic check_line(input string name);
      tests++; if (writes !== LW) begin fails++; $display("FAIL %s_writes: got %0d expected %0d", name, writes, LW); end
      tests++; if (wr_err !== 0) begin fails++; $display("FAIL %s_wrdata: %0d bad writes, first at %0d, expected 0", name, wr_err, first_bad); end
      tests++; if (issued !== LW) begin fails++; $display("FAIL %s_issued: got %0d expected %0d", name, issued, LW); end
      tests++; if (seq_err !== 0) begin fails++; $display("FAIL %s_addr_seq: %0d out-of-order addresses, expected 0", name, seq_err); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      tests++; if (mem_if.mem_request !== 1'b0) begin fails++; $display("FAIL reset_request: got %0b expected 0", mem_if.mem_request); end
      tests++; if (mem_if.mem_read !== 1'b0) begin fails++; $display("FAIL reset_read: got %0b expected 0", mem_if.mem_read); end
      tests++; if (mem_if.mem_address !== '0) begin fails++; $display("FAIL reset_address: got %h expected 0", mem_if.mem_address); end
      tests++; if (dvalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", dvalid); end
      tests++; if (col !== '0 || ddata !== '0) begin fails++; $display("FAIL reset_wrport: col %0d data %h expected 0/0", col, ddata); end
`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
`endif
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_basic_line();
      lat = 3; rnd_ready = 1'b0;
      pulse_start(BANK1_BASE, 1'b1);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_rise: got %0b expected 1", busy); end
      wait_idle("basic");
      check_line("basic");
      tests++; if (busy_fall_cyc - last_wr_cyc !== 1) begin fails++; $display("FAIL basic_busy_fall: busy fell %0d cycles after col 511 write, expected 1", busy_fall_cyc - last_wr_cyc); end
      tests++; if (episodes !== 32) begin fails++; $display("FAIL basic_grants: got %0d expected 32", episodes); end
   endtask

   task automatic test_random_ready();
      lat = 1; rnd_ready = 1'b1;
      pulse_start(20'h01000, 1'b1);
      wait_idle("rnd_ready");
      check_line("rnd_ready");
      tests++; if (episodes !== 32) begin fails++; $display("FAIL rnd_ready_grants: got %0d expected 32", episodes); end
      rnd_ready = 1'b0;
   endtask

   task automatic test_grant_revoke();
      lat = 3; revoke_at = 5;
      pulse_start(20'h00400, 1'b1);
      wait_idle("revoke");
      check_line("revoke");
      tests++; if (read_after_revoke !== 1'b0) begin fails++; $display("FAIL revoke_read_drop: read=%b cycle after revoke, expected 0", read_after_revoke); end
      tests++; if (resume_addr !== 20'h00405) begin fails++; $display("FAIL revoke_resume: got %h expected 00405", resume_addr); end
      tests++; if (episodes !== 33) begin fails++; $display("FAIL revoke_grants: got %0d expected 33", episodes); end
   endtask

   task automatic test_start_while_busy();
      lat = 3;
      pulse_start(20'h20000, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      pulse_start(20'h33333, 1'b0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_start_busy: got %0b expected 1", busy); end
`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL busy_start_overrun_set: got %0b expected 1", overrun); end
`endif
      wait_idle("busy_start");
      check_line("busy_start");
`ifdef DISPLAY_LINE_FETCHER_OVERRUN_EN
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL busy_start_overrun_sticky: got %0b expected 1", overrun); end
      ovr_clr = 1'b1;
      @(posedge clk); #1;
      ovr_clr = 1'b0;
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL busy_start_overrun_clear: got %0b expected 0", overrun); end
`endif
   endtask

   task automatic test_wrap();
      lat = 2;
      pulse_start(20'hFFF00, 1'b1);
      wait_idle("wrap");
      check_line("wrap");
      tests++; if (col256_data !== mem_word(20'h00000)) begin fails++; $display("FAIL wrap_col256: got %h expected %h", col256_data, mem_word(20'h00000)); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      lat = 6;
      pulse_start(20'h40000, 1'b1);
      while (writes <= 200 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      tests++; if (writes <= 200) begin fails++; $display("FAIL rst_mid_reach_col200: got %0d writes expected >200", writes); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0 || mem_if.mem_request !== 1'b0 || mem_if.mem_read !== 1'b0) begin
         fails++; $display("FAIL rst_mid_ctrl: busy/req/read=%b%b%b expected 000", busy, mem_if.mem_request, mem_if.mem_read); end
      tests++; if (dvalid !== 1'b0 || col !== '0 || ddata !== '0 || mem_if.mem_address !== '0) begin
         fails++; $display("FAIL rst_mid_data: valid %b col %0d data %h addr %h expected all 0", dvalid, col, ddata, mem_if.mem_address); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_stats();
      repeat (12) @(posedge clk);
      #1;
      tests++; if (writes !== 0) begin fails++; $display("FAIL rst_mid_spurious: got %0d writes expected 0", writes); end
      lat = 3;
      pulse_start(20'h40000, 1'b1);
      wait_idle("rst_mid_refetch");
      check_line("rst_mid_refetch");
   endtask

   initial begin
      test_reset();
      test_basic_line();
      test_random_ready();
      test_grant_revoke();
      test_start_while_busy();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
